// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port between the instruction-fetch
// side and the load/store side. One transaction is outstanding at a time, and
// the two sides take turns when both request together.
//
// Ports:
//   clk, resetn            core clock, synchronous active-low reset
//   inst_* / data_*        requester handshakes:
//                          req/wstrb/addr/wdata in, addr_ok (combinational accept),
//                          data_ok (one-cycle response pulse), rdata
//   mem_req/we/addr/wdata  downstream request, registered or state-decoded
//   mem_gnt                downstream accept while mem_req is high
//   mem_rvalid/mem_rdata   downstream response
module mem_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  state_t         state;
  state_t         state_nx;
  owner_t         last_grant;
  owner_t         owner;
  logic [SW-1:0]  req_we;
  logic [AW-1:0]  req_addr;
  logic [DW-1:0]  req_wdata;
  logic [DW-1:0]  rsp_rdata;

  logic           grant_inst_c;
  logic           grant_data_c;
  logic           accept_c;

  // Round-robin pick: on contention the side that did not win last time goes.
  always_comb begin
    grant_data_c = data_req && (!inst_req || (last_grant == OWN_INST));
    grant_inst_c = inst_req && !grant_data_c;
    accept_c     = (state == S_IDLE) && (grant_inst_c || grant_data_c);
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nx     = state;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    mem_req      = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    unique case (state)
      S_IDLE: begin
        inst_addr_ok = grant_inst_c;
        data_addr_ok = grant_data_c;
        if (accept_c) state_nx = S_REQ;
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) state_nx = S_RESP;
      end
      S_RESP: begin
        inst_data_ok = (owner == OWN_INST);
        data_data_ok = (owner == OWN_DATA);
        state_nx     = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Request latch, grant history and read-data capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= OWN_INST;
      owner      <= OWN_INST;
      req_we     <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      rsp_rdata  <= '0;
    end else begin
      if (accept_c) begin
        owner      <= grant_data_c ? OWN_DATA : OWN_INST;
        last_grant <= grant_data_c ? OWN_DATA : OWN_INST;
        req_we     <= grant_data_c ? data_wstrb : inst_wstrb;
        req_addr   <= grant_data_c ? data_addr  : inst_addr;
        req_wdata  <= grant_data_c ? data_wdata : inst_wdata;
      end
      // Writes leave the last read data visible on rdata.
      if ((state == S_WAIT) && mem_rvalid && (req_we == SW'(0))) begin
        rsp_rdata <= mem_rdata;
      end
    end
  end

  assign mem_we     = req_we;
  assign mem_addr   = req_addr;
  assign mem_wdata  = req_wdata;
  assign inst_rdata = rsp_rdata;
  assign data_rdata = rsp_rdata;

endmodule
